// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel front end: default image geometry and the
// 3x3 window tap ordering used by both the window generator and the gradient stage.
package sobel_pkg;

   localparam int PIXEL_WIDTH_DEF = 8;
   localparam int IMG_WIDTH_DEF   = 640;
   localparam int IMG_HEIGHT_DEF  = 480;

   localparam int WIN_TAPS = 9;
   localparam int WIN_TL   = 0;
   localparam int WIN_T    = 1;
   localparam int WIN_TR   = 2;
   localparam int WIN_L    = 3;
   localparam int WIN_C    = 4;
   localparam int WIN_R    = 5;
   localparam int WIN_BL   = 6;
   localparam int WIN_B    = 7;
   localparam int WIN_BR   = 8;

   localparam int WIN_FLAT_W = PIXEL_WIDTH_DEF * WIN_TAPS;

   function automatic int win_flat_width(input int pixel_width);
      return pixel_width * WIN_TAPS;
   endfunction

endpackage

// File: rtl/sobel_line_mem.sv
// One line of pixel storage: a single address is read (old contents) and
// written in the same cycle, so the caller sees read-before-write data.
module sobel_line_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 640,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator feeding the Sobel gradient stage; emits one
// registered window per accepted interior pixel with its centre coordinates.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
   parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
   parameter int COL_W       = $clog2(IMG_WIDTH),
   parameter int ROW_W       = $clog2(IMG_HEIGHT)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            pixel_valid,
   input  logic [PIXEL_WIDTH-1:0]          pixel_in,
   input  logic                            sof,
   output logic                            window_valid,
   output logic [PIXEL_WIDTH*WIN_TAPS-1:0] window_flat,
   output logic [COL_W-1:0]                win_x,
   output logic [ROW_W-1:0]                win_y,
   output logic                            frame_done
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0] col_q, col_d, cur_col;
   logic [ROW_W-1:0] row_q, row_d, cur_row;
   logic [WIN_TAPS-1:0][PIXEL_WIDTH-1:0] win_q, win_d;
   logic [PIXEL_WIDTH-1:0] lm0_rd, lm1_rd;
   logic emit, last_px;

   logic                            valid_q;
   logic                            done_q;
   logic [PIXEL_WIDTH*WIN_TAPS-1:0] flat_q;
   logic [COL_W-1:0]                x_q;
   logic [ROW_W-1:0]                y_q;

   sobel_line_mem #(.DATA_W(PIXEL_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lm0 (
      .clk     (clk),
      .we_i    (pixel_valid),
      .addr_i  (cur_col),
      .wdata_i (lm1_rd),
      .rdata_o (lm0_rd)
   );

   sobel_line_mem #(.DATA_W(PIXEL_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lm1 (
      .clk     (clk),
      .we_i    (pixel_valid),
      .addr_i  (cur_col),
      .wdata_i (pixel_in),
      .rdata_o (lm1_rd)
   );

   always_comb begin
      // sof re-labels the current pixel as (0,0), overriding any frame in progress
      cur_col = sof ? '0 : col_q;
      cur_row = sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      emit    = 1'b0;
      last_px = 1'b0;
      if (pixel_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
         win_d[WIN_TL] = win_q[WIN_T];
         win_d[WIN_T]  = win_q[WIN_TR];
         win_d[WIN_TR] = lm0_rd;
         win_d[WIN_L]  = win_q[WIN_C];
         win_d[WIN_C]  = win_q[WIN_R];
         win_d[WIN_R]  = lm1_rd;
         win_d[WIN_BL] = win_q[WIN_B];
         win_d[WIN_B]  = win_q[WIN_BR];
         win_d[WIN_BR] = pixel_in;
         emit    = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
         last_px = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      end else if (sof) begin
         col_d = '0;
         row_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         flat_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         valid_q <= emit;
         done_q  <= emit && last_px;
         if (emit) begin
            flat_q <= win_d;
            x_q    <= cur_col - 1'b1;
            y_q    <= cur_row - 1'b1;
         end
      end
   end

   assign window_valid = valid_q;
   assign window_flat  = flat_q;
   assign win_x        = x_q;
   assign win_y        = y_q;
   assign frame_done   = done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x6 image: scenario table of whole
// frames plus hand sequences for sof abort, mid-frame reset and idle sof.
module tb_sobel_window_gen;

   localparam int PW = 8;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pixel_valid;
   logic [PW-1:0]     pixel_in;
   logic              sof;
   logic              window_valid;
   logic [PW*9-1:0]   window_flat;
   logic [CW-1:0]     win_x;
   logic [RW-1:0]     win_y;
   logic              frame_done;

   sobel_window_gen #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pixel_valid  (pixel_valid),
      .pixel_in     (pixel_in),
      .sof          (sof),
      .window_valid (window_valid),
      .window_flat  (window_flat),
      .win_x        (win_x),
      .win_y        (win_y),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pat;
      int gap;
      bit use_sof;
      int exp_win;
      int exp_done;
   } scen_t;

   int tests = 0;
   int fails = 0;
   int nwin  = 0;
   int ndone = 0;

   logic            exp_valid;
   logic            exp_done;
   logic [CW-1:0]   exp_x;
   logic [RW-1:0]   exp_y;
   logic [PW*9-1:0] exp_flat;

   bit              cap_first, got_first, cap_step, got_step;
   logic [PW*9-1:0] first_flat, step_flat;
   logic [CW-1:0]   first_x;
   logic [RW-1:0]   first_y;

   function automatic logic [7:0] pix(input int pat, input int r, input int c);
      case (pat)
         0:       return 8'(r*16 + c);
         1:       return 8'(255 - (r*16 + c));
         default: return (c < W/2) ? 8'h00 : 8'hFF;
      endcase
   endfunction

   function automatic logic [PW*9-1:0] win_of(input int pat, input int r, input int c);
      logic [PW*9-1:0] f;
      f = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            f[PW*(i*3+j) +: PW] = pix(pat, r-2+i, c-2+j);
      return f;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // called on the falling edge; compares all outputs against the model
   task automatic check_outputs();
      tests++;
      if ({window_valid, frame_done, win_x, win_y, window_flat} !==
          {exp_valid, exp_done, exp_x, exp_y, exp_flat}) begin
         fails++;
         $display("FAIL win @%0t: got v=%0b d=%0b x=%0d y=%0d flat=%h want v=%0b d=%0b x=%0d y=%0d flat=%h",
                  $time, window_valid, frame_done, win_x, win_y, window_flat,
                  exp_valid, exp_done, exp_x, exp_y, exp_flat);
      end
      if (window_valid === 1'b1) nwin++;
      if (frame_done === 1'b1) ndone++;
      if (cap_first && !got_first && window_valid === 1'b1) begin
         got_first = 1; first_flat = window_flat; first_x = win_x; first_y = win_y;
      end
      if (cap_step && !got_step && window_valid === 1'b1 && win_x == CW'(3)) begin
         got_step = 1; step_flat = window_flat;
      end
   endtask

   // entered and left on a falling edge
   task automatic drive(input bit v, input bit s, input int pat, input int r, input int c);
      pixel_valid = v;
      sof         = s;
      pixel_in    = v ? pix(pat, r, c) : 8'h5A;
      @(posedge clk);
      #1;
      if (v && r >= 2 && c >= 2) begin
         exp_valid = 1'b1;
         exp_flat  = win_of(pat, r, c);
         exp_x     = CW'(c - 1);
         exp_y     = RW'(r - 1);
         exp_done  = (r == H-1) && (c == W-1);
      end else begin
         exp_valid = 1'b0;
         exp_done  = 1'b0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send_frame(input int pat, input int gap, input bit use_sof,
                             input int last_r, input int last_c);
      for (int r = 0; r <= last_r; r++)
         for (int c = 0; c < W; c++) begin
            if (r == last_r && c > last_c) break;
            while (int'($urandom_range(99)) < gap) drive(0, 0, pat, 0, 0);
            drive(1, use_sof && r == 0 && c == 0, pat, r, c);
         end
   endtask

   task automatic do_reset();
      pixel_valid = 1'b0;
      sof         = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", {window_valid, frame_done, win_x, win_y, window_flat}, '0);
      exp_valid = 0; exp_done = 0; exp_x = '0; exp_y = '0; exp_flat = '0;
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
   endtask

   scen_t scen [5];
   int    w0, d0, gx;
   int    p [9];

   initial begin
      scen[0] = '{pat: 0, gap: 0,  use_sof: 1, exp_win: 24, exp_done: 1};
      scen[1] = '{pat: 0, gap: 40, use_sof: 1, exp_win: 24, exp_done: 1};
      scen[2] = '{pat: 1, gap: 0,  use_sof: 0, exp_win: 24, exp_done: 1};
      scen[3] = '{pat: 0, gap: 0,  use_sof: 1, exp_win: 24, exp_done: 1};
      scen[4] = '{pat: 2, gap: 0,  use_sof: 1, exp_win: 24, exp_done: 1};

      rst_n = 1'b1; pixel_valid = 1'b0; sof = 1'b0; pixel_in = '0;
      cap_first = 0; got_first = 0; cap_step = 0; got_step = 0;
      first_flat = '0; step_flat = '0; first_x = '0; first_y = '0;
      @(negedge clk);
      do_reset();
      check("reset_valid", 128'(window_valid), 128'(0));
      check("reset_flat",  128'(window_flat),  128'(0));
      check("reset_xy",    128'({win_x, win_y}), 128'(0));

      for (int i = 0; i < 5; i++) begin
         cap_first = (i == 0);
         cap_step  = (i == 4);
         w0 = nwin; d0 = ndone;
         send_frame(scen[i].pat, scen[i].gap, scen[i].use_sof, H-1, W-1);
         check($sformatf("scen%0d_windows", i), 128'(nwin - w0), 128'(scen[i].exp_win));
         check($sformatf("scen%0d_done", i),    128'(ndone - d0), 128'(scen[i].exp_done));
      end
      drive(0, 0, 0, 0, 0);

      check("first_seen", 128'(got_first), 128'(1));
      check("first_x",  128'(first_x), 128'(1));
      check("first_y",  128'(first_y), 128'(1));
      check("first_p0", 128'(first_flat[0*PW +: PW]), 128'(8'h00));
      check("first_p2", 128'(first_flat[2*PW +: PW]), 128'(8'h02));
      check("first_p4", 128'(first_flat[4*PW +: PW]), 128'(8'h11));
      check("first_p6", 128'(first_flat[6*PW +: PW]), 128'(8'h20));
      check("first_p8", 128'(first_flat[8*PW +: PW]), 128'(8'h22));

      check("step_seen", 128'(got_step), 128'(1));
      for (int k = 0; k < 9; k++) p[k] = int'(step_flat[PW*k +: PW]);
      check("step_right", 128'({p[2], p[5], p[8]}), 128'({32'hFF, 32'hFF, 32'hFF}));
      check("step_left",  128'({p[0], p[3], p[6]}), 128'({32'h0, 32'h0, 32'h0}));
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      check("step_gx", 128'(gx), 128'(1020));

      // sof lands on what would have been pixel (3,4)
      w0 = nwin; d0 = ndone;
      send_frame(0, 0, 1, 3, 3);
      check("abort_windows", 128'(nwin - w0), 128'(8));
      w0 = nwin;
      send_frame(1, 0, 1, H-1, W-1);
      check("abort_new_windows", 128'(nwin - w0), 128'(24));
      check("abort_done", 128'(ndone - d0), 128'(1));

      // reset in the middle of row 3, next frame without sof
      send_frame(0, 0, 1, 3, 3);
      do_reset();
      w0 = nwin; d0 = ndone;
      send_frame(1, 25, 0, H-1, W-1);
      check("rst_frame_windows", 128'(nwin - w0), 128'(24));
      check("rst_frame_done",    128'(ndone - d0), 128'(1));

      // sof without a pixel restarts the counters
      send_frame(0, 0, 1, 1, 5);
      drive(0, 1, 0, 0, 0);
      w0 = nwin; d0 = ndone;
      send_frame(2, 0, 0, H-1, W-1);
      check("idle_sof_windows", 128'(nwin - w0), 128'(24));
      check("idle_sof_done",    128'(ndone - d0), 128'(1));

      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
